node_integrator: RTL and testbench

- Node-side counterpart to the transistor and pad current models: it turns the currents they drive back into a node voltage.
- Each enabled clock it sums up to N_IN signed branch currents, integrates the sum into a signed node voltage clamped to the supply rails, and derives two status flags: a hysteretic digital level and a settled flag.
- One instance per simulated circuit node. Transistor and pad models take their v inputs from this block's v output.

---
 rtl/node_integrator.sv | 158 +++++++++++++++
 tb/tb_node_integrator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/node_integrator.sv
// node_integrator: turns the branch currents driven onto one circuit node back
// into a node voltage. Each enabled clock the signed branch currents are summed,
// scaled by an arithmetic right shift, added to the node voltage and clamped to
// the supply rails. Two status flags are derived alongside the voltage: a
// hysteretic digital level and a settled flag.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   integration step enable
//   i_bus    in   N_IN packed signed currents, input k at [k*W +: W]
//   load     in   force the node voltage to load_v (takes priority over en)
//   load_v   in   signed value written on load (clamped to the rails)
//   v        out  signed node voltage (registered)
//   level    out  hysteretic digital value of v (registered)
//   settled  out  node quiet for SETTLE_CYCLES consecutive steps (registered)
//   sat      out  last step or load was clamped to a rail (registered)
module node_integrator #(
    parameter int unsigned N_IN          = 8,
    parameter int unsigned W             = 16,
    parameter int unsigned SHIFT         = 0,
    parameter int          V_HI          = 32767,
    parameter int          V_LO          = -32768,
    parameter int          V_INIT        = -32768,
    parameter int          VTH_HI        = 16383,
    parameter int          VTH_LO        = -16384,
    parameter int unsigned SETTLE_THRESH = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_IN*W-1:0] i_bus,
    input  logic              load,
    input  logic [W-1:0]      load_v,
    output logic [W-1:0]      v,
    output logic              level,
    output logic              settled,
    output logic              sat
);

    // Sum width holds N_IN full-scale inputs without wrap; one extra bit for v + delta.
    localparam int unsigned SW = W + $clog2(N_IN) + 1;
    localparam int unsigned EW = SW + 1;
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 2);

    localparam logic signed [EW-1:0] RAIL_HI  = EW'(V_HI);
    localparam logic signed [EW-1:0] RAIL_LO  = EW'(V_LO);
    localparam logic signed [EW-1:0] TH_HI    = EW'(VTH_HI);
    localparam logic signed [EW-1:0] TH_LO    = EW'(VTH_LO);
    localparam logic [EW-1:0]        QUIET_TH = EW'(SETTLE_THRESH);
    localparam logic [CW-1:0]        CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [W-1:0]         V_RST    = W'(V_INIT);
    localparam logic                 LVL_RST  = (V_INIT >= VTH_HI);

    logic [W-1:0]  v_q, v_d;
    logic          level_q, level_d;
    logic          settled_q, settled_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] delta;
    logic signed [EW-1:0] v_ext;
    logic signed [EW-1:0] src;
    logic signed [EW-1:0] clamped;
    logic signed [EW-1:0] eff;
    logic [EW-1:0]        eff_mag;
    logic                 clamp_hit;
    logic                 lvl_next;
    logic                 quiet;

    // Sign-extended sum of all branch currents.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            sum = sum + SW'($signed(i_bus[k*W +: W]));
        end
    end

    // Candidate voltage (load or integration step), rail clamp and derived flags.
    always_comb begin
        delta   = sum >>> SHIFT;
        v_ext   = EW'($signed(v_q));
        src     = load ? EW'($signed(load_v)) : (v_ext + EW'(delta));
        clamped = src;
        clamp_hit = 1'b0;
        if (src > RAIL_HI) begin
            clamped   = RAIL_HI;
            clamp_hit = 1'b1;
        end else if (src < RAIL_LO) begin
            clamped   = RAIL_LO;
            clamp_hit = 1'b1;
        end

        // Change actually applied; a node pinned at a rail reads as quiet.
        eff     = clamped - v_ext;
        eff_mag = (eff < 0) ? -eff : eff;
        quiet   = (eff_mag <= QUIET_TH);

        if (clamped >= TH_HI) begin
            lvl_next = 1'b1;
        end else if (clamped <= TH_LO) begin
            lvl_next = 1'b0;
        end else begin
            lvl_next = level_q;
        end
    end

    // Next-state selection: load > en > hold.
    always_comb begin
        v_d       = v_q;
        level_d   = level_q;
        settled_d = settled_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        if (load) begin
            v_d       = W'(clamped);
            level_d   = lvl_next;
            sat_d     = clamp_hit;
            cnt_d     = '0;
            settled_d = 1'b0;
        end else if (en) begin
            v_d     = W'(clamped);
            level_d = lvl_next;
            sat_d   = clamp_hit;
            if (!quiet) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            settled_d = (cnt_d == CNT_MAX);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q       <= V_RST;
            level_q   <= LVL_RST;
            settled_q <= 1'b0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            v_q       <= v_d;
            level_q   <= level_d;
            settled_q <= settled_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
        end
    end

    assign v       = v_q;
    assign level   = level_q;
    assign settled = settled_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_node_integrator.sv
module tb_node_integrator;

    localparam int unsigned N_IN = 8;
    localparam int unsigned W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N_IN*W-1:0] i_bus;
    logic              load;
    logic [W-1:0]      load_v;
    logic [W-1:0]      v;
    logic              level;
    logic              settled;
    logic              sat;

    int checks   = 0;
    int failures = 0;

    node_integrator #(
        .N_IN(N_IN), .W(W), .SHIFT(0),
        .V_HI(1000), .V_LO(-1000), .V_INIT(-1000),
        .VTH_HI(300), .VTH_LO(-300),
        .SETTLE_THRESH(2), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i_bus(i_bus),
        .load(load), .load_v(load_v),
        .v(v), .level(level), .settled(settled), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ev, input int el,
                             input int es, input int esat);
        check({tag, ".v"}, int'($signed(v)), ev);
        check({tag, ".level"}, int'(level), el);
        check({tag, ".settled"}, int'(settled), es);
        check({tag, ".sat"}, int'(sat), esat);
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in0(input int val);
        i_bus = '0;
        i_bus[W-1:0] = W'(val);
    endtask

    task automatic set_all(input int val);
        for (int k = 0; k < int'(N_IN); k++) i_bus[k*W +: W] = W'(val);
    endtask

    task automatic do_load(input int val);
        load   = 1'b1;
        load_v = W'(val);
        step();
        load   = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        load_v = '0;
        i_bus  = '0;
        step();
        step();
        check_all("reset", -1000, 0, 0, 0);
        rst_n = 1'b1;

        // 1: idle cycles hold the reset state
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("idle%0d", i), -1000, 0, 0, 0);
        end

        // 2: constant +100 ramp into the upper rail
        set_in0(100);
        en = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            int ev;
            step();
            ev = (-1000 + 100 * n > 1000) ? 1000 : -1000 + 100 * n;
            check($sformatf("ramp%0d.v", n), int'($signed(v)), ev);
            if (n == 12) check("ramp12.level", int'(level), 0);
            if (n == 13) check("ramp13.level", int'(level), 1);
            if (n == 20) check("ramp20.sat", int'(sat), 0);
            if (n == 21) check("ramp21.sat", int'(sat), 1);
            if (n == 23) check("ramp23.settled", int'(settled), 0);
            if (n == 24) check("ramp24.settled", int'(settled), 1);
        end

        // 3: full-scale inputs must clamp, never wrap
        do_load(0);
        check_all("load0", 0, 1, 0, 0);
        set_all(32767);
        step();
        check_all("pos_fs", 1000, 1, 0, 1);
        set_all(-32768);
        step();
        check_all("neg_fs", -1000, 0, 0, 1);

        // 4: hysteresis band holds level
        do_load(400);
        check_all("load400", 400, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_in0((i % 2 == 0) ? -200 : 200);
            step();
            check_all($sformatf("hyst%0d", i), (i % 2 == 0) ? 200 : 400, 1, 0, 0);
        end
        set_in0(-700);
        step();
        check_all("hyst_fall", -300, 0, 0, 0);

        // 5: load overrides an enabled step and restarts settling
        set_in0(1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_all($sformatf("trickle%0d", i), -300 + i, 0, (i == 4) ? 1 : 0, 0);
        end
        set_in0(50);
        do_load(1500);
        check_all("load_pri", 1000, 1, 0, 1);
        set_in0(0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_all($sformatf("resettle%0d", i), 1000, 1, (i == 4) ? 1 : 0, 0);
        end

        // 6: hold with en=0, then reset during active integration
        en = 1'b0;
        set_in0(-500);
        step();
        step();
        check_all("hold", 1000, 1, 1, 0);
        en = 1'b1;
        step();
        check_all("run", 500, 1, 0, 0);
        rst_n = 1'b0;
        step();
        check_all("mid_reset", -1000, 0, 0, 0);
        rst_n = 1'b1;
        en    = 1'b0;
        step();
        check_all("post_reset", -1000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
